// File: rtl/ray_generator.sv
// rtl/ray_generator.sv - raster-order camera ray direction generator
// Emits one unnormalised Q4.8 ray per clock, tagged with a wrapping nonzero ID.
module ray_generator #(
  parameter int                 H_RES    = 16,
  parameter int                 V_RES    = 16,
  parameter int                 ID_WIDTH = 8,
  parameter logic signed [11:0] STEP     = 12'sd32,
  parameter logic signed [11:0] FOCAL    = 12'sd256
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       hold,
  output logic signed [11:0]         x_out,
  output logic signed [11:0]         y_out,
  output logic signed [11:0]         z_out,
  output logic        [ID_WIDTH-1:0] out_id,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int CW     = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int RW     = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int X0_MAG = (H_RES / 2) * int'(STEP);
  localparam int Y0_MAG = (V_RES / 2) * int'(STEP);
  localparam int X0_ABS = (X0_MAG < 0) ? -X0_MAG : X0_MAG;
  localparam int Y0_ABS = (Y0_MAG < 0) ? -Y0_MAG : Y0_MAG;
  localparam logic signed [11:0] X0 = 12'(-X0_MAG);
  localparam logic signed [11:0] Y0 = 12'(Y0_MAG);

  // Edge-of-frame directions must fit the signed 12-bit accumulators.
  if (X0_ABS > 2047 || Y0_ABS > 2047) begin : g_range_check
    $error("ray_generator: X0/Y0 magnitude exceeds Q4.8 range");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic [CW-1:0]             r_col;
  logic [RW-1:0]             r_row;
  logic signed [11:0]        r_x;
  logic signed [11:0]        r_y;
  logic [ID_WIDTH-1:0]       r_id;
  logic signed [11:0]        r_x_out;
  logic signed [11:0]        r_y_out;
  logic signed [11:0]        r_z_out;
  logic [ID_WIDTH-1:0]       r_id_out;
  logic                      r_busy;
  logic                      r_frame_done;

  logic w_start_frame;
  logic w_issue;
  logic w_last_col;
  logic w_last_pixel;

  assign w_start_frame = (r_state == IDLE) && start;
  assign w_issue       = (r_state == RUN) && !hold;
  assign w_last_col    = (r_col == CW'(H_RES - 1));
  assign w_last_pixel  = w_last_col && (r_row == RW'(V_RES - 1));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (w_issue && w_last_pixel) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_id         <= ID_WIDTH'(1);
      r_x_out      <= '0;
      r_y_out      <= '0;
      r_z_out      <= '0;
      r_id_out     <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_busy       <= (w_next_state != IDLE);
      r_frame_done <= (w_next_state == DONE);
      r_x_out      <= '0;
      r_y_out      <= '0;
      r_z_out      <= '0;
      r_id_out     <= '0;
      if (w_start_frame) begin
        r_col <= '0;
        r_row <= '0;
        r_x   <= X0;
        r_y   <= Y0;
      end else if (w_issue) begin
        r_x_out  <= r_x;
        r_y_out  <= r_y;
        r_z_out  <= FOCAL;
        r_id_out <= r_id;
        // Tag 0 is reserved for bubbles, so the wrap lands on 1.
        r_id     <= (r_id == '1) ? ID_WIDTH'(1) : r_id + ID_WIDTH'(1);
        if (w_last_col) begin
          r_col <= '0;
          r_row <= r_row + RW'(1);
          r_x   <= X0;
          r_y   <= r_y - STEP;
        end else begin
          r_col <= r_col + CW'(1);
          r_x   <= r_x + STEP;
        end
      end
    end
  end

  assign x_out      = r_x_out;
  assign y_out      = r_y_out;
  assign z_out      = r_z_out;
  assign out_id     = r_id_out;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_ray_generator.sv
// tb/tb_ray_generator.sv - directed self-checking bench for ray_generator
// Uses a 4x2 frame with STEP=FOCAL=1.0 so every ray value is easy to hand-check.
module tb_ray_generator;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               hold  = 1'b0;
  logic signed [11:0] x_out;
  logic signed [11:0] y_out;
  logic signed [11:0] z_out;
  logic [7:0]         out_id;
  logic               busy;
  logic               frame_done;

  int n_pass  = 0;
  int n_total = 0;

  ray_generator #(
    .H_RES(4), .V_RES(2), .ID_WIDTH(8), .STEP(12'sd256), .FOCAL(12'sd256)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .hold(hold),
    .x_out(x_out), .y_out(y_out), .z_out(z_out), .out_id(out_id),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  logic [45:0] obs;
  assign obs = {x_out, y_out, z_out, out_id, busy, frame_done};

  // Hand-computed ray table for the 4x2 frame: pixel k -> (x, y), z = 256.
  int xs [8] = '{-512, -256, 0, 256, -512, -256, 0, 256};
  int ys [8] = '{ 256,  256, 256, 256,  0,    0,  0,   0};

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    hold  = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [45:0] want;
    start = 1'b0;
    hold  = 1'b0;
    #1 reset = 1'b0;
    #1;
    want = '0;
    n_total++;
    if (obs !== want) $display("FAIL reset_async got %h want %h", obs, want);
    else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      n_total++;
      if (obs !== want) $display("FAIL reset_idle cycle=%0d got %h want %h", i, obs, want);
      else n_pass++;
    end
  endtask

  task automatic test_frame();
    logic [45:0] want;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    want = {12'sd0, 12'sd0, 12'sd0, 8'd0, 1'b1, 1'b0};
    n_total++;
    if (obs !== want) $display("FAIL frame_armed got %h want %h", obs, want);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      want = {12'(xs[k]), 12'(ys[k]), 12'sd256, 8'(k + 1), 1'b1, (k == 7)};
      n_total++;
      if (obs !== want) $display("FAIL frame_ray k=%0d got %h want %h", k, obs, want);
      else n_pass++;
    end
    @(negedge clock);
    want = '0;
    n_total++;
    if (obs !== want) $display("FAIL frame_after got %h want %h", obs, want);
    else n_pass++;
  endtask

  task automatic test_hold();
    int          seq [10] = '{0, 1, -1, -1, 2, 3, 4, 5, 6, 7};
    logic [45:0] want;
    pulse_reset();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (seq[i] < 0) want = {12'sd0, 12'sd0, 12'sd0, 8'd0, 1'b1, 1'b0};
      else want = {12'(xs[seq[i]]), 12'(ys[seq[i]]), 12'sd256, 8'(seq[i] + 1), 1'b1, (seq[i] == 7)};
      n_total++;
      if (obs !== want) $display("FAIL hold_seq cycle=%0d got %h want %h", i, obs, want);
      else n_pass++;
      hold = (i == 1 || i == 2);
    end
    @(negedge clock);
    want = '0;
    n_total++;
    if (obs !== want) $display("FAIL hold_after got %h want %h", obs, want);
    else n_pass++;
  endtask

  task automatic test_hold_last();
    int          seq [10] = '{0, 1, 2, 3, 4, 5, 6, -1, -1, 7};
    logic [45:0] want;
    pulse_reset();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (seq[i] < 0) want = {12'sd0, 12'sd0, 12'sd0, 8'd0, 1'b1, 1'b0};
      else want = {12'(xs[seq[i]]), 12'(ys[seq[i]]), 12'sd256, 8'(seq[i] + 1), 1'b1, (seq[i] == 7)};
      n_total++;
      if (obs !== want) $display("FAIL hold_last cycle=%0d got %h want %h", i, obs, want);
      else n_pass++;
      hold = (i == 6 || i == 7);
    end
    @(negedge clock);
    n_total++;
    if (busy !== 1'b0) $display("FAIL hold_last_idle busy got %0b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back_id_wrap();
    int         rays = 0;
    logic [7:0] eid;
    pulse_reset();
    @(negedge clock);
    start = 1'b1;
    // Start held high: it must be ignored mid-frame and rearm each frame from IDLE.
    for (int c = 0; c < 400 && rays < 256; c++) begin
      @(negedge clock);
      if (z_out == 12'sd256) begin
        rays++;
        eid = 8'(((rays - 1) % 255) + 1);
        n_total++;
        if (out_id !== eid) $display("FAIL id_wrap ray=%0d got %0d want %0d", rays, out_id, eid);
        else n_pass++;
      end
    end
    start = 1'b0;
    n_total++;
    if (rays != 256) $display("FAIL id_wrap_count got %0d want 256", rays);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (busy !== 1'b0) $display("FAIL id_wrap_idle busy got %0b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_start_reset_midrun();
    logic [45:0] want;
    pulse_reset();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      want = {12'(xs[k]), 12'(ys[k]), 12'sd256, 8'(k + 1), 1'b1, 1'b0};
      n_total++;
      if (obs !== want) $display("FAIL midrun_ray k=%0d got %h want %h", k, obs, want);
      else n_pass++;
      start = (k == 2);
    end
    reset = 1'b0;
    #1;
    want = '0;
    n_total++;
    if (obs !== want) $display("FAIL midrun_reset got %h want %h", obs, want);
    else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    want = {12'sd0 - 12'sd512, 12'sd256, 12'sd256, 8'd1, 1'b1, 1'b0};
    n_total++;
    if (obs !== want) $display("FAIL restart_first got %h want %h", obs, want);
    else n_pass++;
    for (int c = 0; c < 20 && busy; c++) @(negedge clock);
    n_total++;
    if (busy !== 1'b0) $display("FAIL restart_idle busy got %0b want 0", busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_hold();
    test_hold_last();
    test_back_to_back_id_wrap();
    test_start_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ray_generator.md
RAY_GENERATOR -- requirements
Module: ray_generator

Interface
REQ-001 The block SHALL have parameter H_RES, default 16, giving the number of columns per frame (even, 2..256).
REQ-002 The block SHALL have parameter V_RES, default 16, giving the number of rows per frame (even, 2..256).
REQ-003 The block SHALL have parameter ID_WIDTH, default 8, giving the ray tag width.
REQ-004 The block SHALL have parameter STEP, default 12'sd32, giving the per-pixel increment in Q4.8 (0.125).
REQ-005 The block SHALL have parameter FOCAL, default 12'sd256, giving the constant z component in Q4.8 (1.0).
REQ-006 The block SHALL have port clock, input, 1, the single clock; all state changes occur on its rising edge.
REQ-007 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have port start, input, 1, a request to begin one frame.
REQ-009 The block SHALL have port hold, input, 1, which inserts a bubble instead of the next ray.
REQ-010 The block SHALL have ports x_out, y_out and z_out, output, signed 12 each, giving the unnormalised Q4.8 direction that feeds vector_normalization x_in/y_in/z_in.
REQ-011 The block SHALL have port out_id, output, ID_WIDTH, giving the ray tag; 0 = bubble/no ray.
REQ-012 The block SHALL have port busy, output, 1, high whenever the FSM is not IDLE.
REQ-013 The block SHALL have port frame_done, output, 1, a one-cycle end-of-frame indication.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-015 The FSM SHALL make these transitions:
- IDLE->RUN on an edge with start=1; the column/row counters and the x/y accumulators load their initial values.
- RUN->DONE on the edge that issues pixel (H_RES-1, V_RES-1).
- DONE->IDLE on the next edge, unconditionally.
REQ-016 The block SHALL ignore start while in RUN or DONE, with no restart and no queuing.
REQ-017 All outputs SHALL be registered.
REQ-018 On each RUN edge with hold=0, the block SHALL load the output registers with the current ray and advance the column counter; at column wrap, the column resets to 0 and the row increments.
REQ-019 On each RUN edge with hold=1, the block SHALL load x/y/z/out_id with 0 and leave the counters, accumulators and ID counter unchanged.
REQ-020 On edges in IDLE or DONE, the block SHALL load x/y/z/out_id with 0 (bubble).
REQ-021 The ray direction SHALL be computed as follows:
- x = X0 + col*STEP, where X0 = -(H_RES/2)*STEP.
- y = Y0 - row*STEP, where Y0 = (V_RES/2)*STEP.
- z = FOCAL.
- x and y are computed incrementally by add/subtract of STEP; no multiplier.
REQ-022 The block SHALL flag at elaboration the out-of-range case, max(|X0|, |Y0|) > 2047, as an error; no runtime saturation is required.
REQ-023 Rays SHALL be issued in raster order: row 0 first, columns 0..H_RES-1 within each row.
REQ-024 Start-to-first-ray latency SHALL be 1 cycle: with start sampled at edge N, ray (0,0) appears after edge N+1.
REQ-025 With hold=0 throughout, the block SHALL issue H_RES*V_RES rays on consecutive cycles, with throughput 1 ray/clock matching the normalizer.
REQ-026 frame_done SHALL be high exactly while the state is DONE, i.e. in the same cycle the last ray of the frame is on the outputs.
REQ-027 If hold=1 on the would-be-last pixel, the block SHALL remain in RUN; DONE is entered only when that pixel is actually issued.
REQ-028 The ID counter SHALL work as follows:
- Each issued ray takes the current ID, then the counter increments.
- The counter wraps from 2^ID_WIDTH-1 to 1, skipping 0.
- The counter persists across frames and is reset only by reset.
REQ-029 On a start edge, hold SHALL have no effect; hold is sampled only in RUN.

Reset
REQ-030 While reset=0, the block SHALL immediately, asynchronously, set:
- state = IDLE;
- x/y/z_out = 0 and out_id = 0;
- busy = 0 and frame_done = 0;
- counters = 0;
- ID counter = 1.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; after release, the next start begins at pixel (0,0) with ID 1.

Verification
REQ-032 Reset: drive reset=0 -> all outputs 0, busy=0; release with no start -> outputs stay 0 for 20 cycles.
REQ-033 Frame with H_RES=4, V_RES=2, STEP=256, FOCAL=256, start pulse, hold=0 -> the following sequence appears on 8 consecutive cycles:
- (-512,256,256) id1
- (-256,256,256) id2
- (0,256,256) id3
- (256,256,256) id4
- (-512,0,256) id5
- ... ending at (256,0,256) id8 with frame_done=1 in that cycle.
- Then bubbles, busy=0.
REQ-034 Hold (same parameters): hold=1 for 2 cycles after id2 -> two bubbles (0,0,0) id0, then (0,256,256) id3; the frame ends 2 cycles later than in REQ-033.
REQ-035 Hold on last pixel: hold=1 while (256,0,256) is pending -> frame_done stays 0 and busy=1; hold=0 -> id8 issued with frame_done=1.
REQ-036 ID wrap: run 32 back-to-back 8-ray frames -> IDs run 1..255, then ray 256 carries id1; out_id is never 0 on a ray.
REQ-037 Start mid-run and reset mid-run: start pulsed at the id3 cycle -> ignored, the frame completes normally; reset=0 at the id5 cycle -> outputs 0 at once; a new start -> (-512,256,256) id1.
